// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_PORTS requesters.
// One grant per cycle. A response pulse comes back one cycle later, matching the SRAM read latency.
module sram_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 131072,
   localparam int AW        = $clog2(NUM_WORDS)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_PORTS-1:0]            req_i,
   input  logic [NUM_PORTS-1:0]            we_i,
   input  logic [NUM_PORTS*AW-1:0]         addr_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] be_i,
   output logic [NUM_PORTS-1:0]            gnt_o,
   output logic [NUM_PORTS-1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0]           rdata_o,
   output logic                            sram_req_o,
   output logic                            sram_we_o,
   output logic [AW-1:0]                   sram_addr_o,
   output logic [DATA_WIDTH-1:0]           sram_wdata_o,
   output logic [DATA_WIDTH-1:0]           sram_be_o,
   input  logic [DATA_WIDTH-1:0]           sram_rdata_i
);

   // Handshake: a request transfers in any cycle where req_i[p] && gnt_o[p].
   // The requester holds its request fields stable until granted, and it may withdraw before the grant.
   // rvalid_o[p] pulses exactly one cycle after each transfer. For a read, rdata_o is valid in that same cycle.

   localparam int PW = $clog2(NUM_PORTS);

   logic [PW-1:0]        ptr_q, ptr_d;
   logic [NUM_PORTS-1:0] rsp_q;
   logic [NUM_PORTS-1:0] gnt_raw;
   logic [PW-1:0]        gnt_idx;
   logic [PW:0]          cand;
   logic                 found;
   logic                 gnt_any;

   // Scan from ptr_q upward. The index wraps explicitly, so non-power-of-two port counts work.
   always_comb begin
      gnt_raw = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(i);
         if (cand >= (PW+1)'(NUM_PORTS)) begin
            cand = cand - (PW+1)'(NUM_PORTS);
         end
         if (!found && req_i[cand[PW-1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[PW-1:0];
         end
      end
      if (found) begin
         gnt_raw[gnt_idx] = 1'b1;
      end
   end

   assign gnt_any = found & rst_ni;
   assign gnt_o   = rst_ni ? gnt_raw : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

   // When nothing is granted the mux falls back to port 0. sram_req_o keeps the SRAM idle.
   always_comb begin
      sram_we_o    = we_i[0];
      sram_addr_o  = addr_i[AW-1:0];
      sram_wdata_o = wdata_i[DATA_WIDTH-1:0];
      sram_be_o    = be_i[DATA_WIDTH-1:0];
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_o[p]) begin
            sram_we_o    = we_i[p];
            sram_addr_o  = addr_i[p*AW +: AW];
            sram_wdata_o = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            sram_be_o    = be_i[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sram_req_o = gnt_any;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
         rsp_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         rsp_q <= gnt_o;
      end
   end

   assign rvalid_o = rsp_q;
   assign rdata_o  = sram_rdata_i;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares one single-port `sram` instance between `NUM_PORTS` requesters. It sits directly in front of the SRAM macro/model and forwards one granted request per cycle. It returns a per-port response pulse one cycle after each grant, which matches the SRAM's one-cycle registered-address read latency. Fairness state is a rotating priority pointer updated on every grant.

## Interface
- `NUM_PORTS`, default 2: number of requesters, ≥ 2.
- `DATA_WIDTH`, default 32: data and bit-enable width, matches `sram`.
- `NUM_WORDS`, default 131072: SRAM depth. `AW = $clog2(NUM_WORDS)` is derived, not overridable.

Ports (per-port buses are flattened, port p occupies slice `[p*W +: W]`):
- `clk_i` input 1: single clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_i` input NUM_PORTS: per-port request.
- `we_i` input NUM_PORTS: per-port write enable (1 = write, 0 = read).
- `addr_i` input NUM_PORTS*AW: per-port word address.
- `wdata_i` input NUM_PORTS*DATA_WIDTH: per-port write data.
- `be_i` input NUM_PORTS*DATA_WIDTH: per-port bit enables.
- `gnt_o` output NUM_PORTS: per-port grant, one-hot or zero.
- `rvalid_o` output NUM_PORTS: per-port response valid, one-hot or zero.
- `rdata_o` output DATA_WIDTH: read data, shared by all ports; qualify with `rvalid_o`.
- `sram_req_o` output 1: to `sram.req_i`.
- `sram_we_o` output 1: to `sram.we_i`.
- `sram_addr_o` output AW: to `sram.addr_i`.
- `sram_wdata_o` output DATA_WIDTH: to `sram.wdata_i`.
- `sram_be_o` output DATA_WIDTH: to `sram.be_i`.
- `sram_rdata_i` input DATA_WIDTH: from `sram.rdata_o`.

## Operation
- **Handshake.** A request is transferred in a cycle where `req_i[p]` and `gnt_o[p]` are both high.
  - A requester holds `req_i[p]`, `we_i[p]`, `addr_i[p]`, `wdata_i[p]` and `be_i[p]` stable until granted.
  - Deasserting `req_i[p]` before grant is allowed; no transfer occurs.
- **Arbitration.** Combinational within the cycle.
  - Priority order is `ptr_q`, `ptr_q+1`, … modulo NUM_PORTS.
  - The first port with `req_i` high is granted.
  - At most one `gnt_o` bit is high; `gnt_o` is all zero when no request is present.
- **Pointer (`ptr_q`, width `$clog2(NUM_PORTS)`).**
  - On a grant to port g, `ptr_q <= (g+1) mod NUM_PORTS`.
  - With no grant, `ptr_q` holds.
  - The wrap from NUM_PORTS-1 back to 0 is explicit (no reliance on power-of-two overflow).
- **SRAM forwarding.**
  - `sram_req_o = |gnt_o`.
  - `sram_we_o`, `sram_addr_o`, `sram_wdata_o` and `sram_be_o` are muxed from the granted port.
  - With no grant the mux selects port 0, but `sram_req_o = 0`.
- **Response tracking.**
  - Registered one-hot `rsp_q <= gnt_o` every cycle.
  - `rvalid_o = rsp_q`.
  - `rdata_o = sram_rdata_i` (unregistered).
- **Writes.** A write also produces an `rvalid_o` pulse as its write acknowledge. `rdata_o` is don't-care on a write response: the SRAM keeps its last read address.
- **Throughput.** One transfer per cycle sustained. Back-to-back grants to different ports are permitted.
- **Data path.** No buffering or reordering. Responses return in grant order, exactly one per grant.

## Timing
- **Reset values.**
  - While `rst_ni` = 0: `ptr_q` = 0, `rsp_q` = 0, so `rvalid_o` = 0.
  - `gnt_o` and `sram_req_o` are forced to 0 while `rst_ni` is low, regardless of `req_i`.
  - `rdata_o` follows `sram_rdata_i` (undefined until the first read).
- **Grant latency.** 0 cycles: `gnt_o` is valid in the same cycle `req_i` rises, if the port wins.
- **Response latency.** Exactly 1 cycle. A grant in cycle N gives `rvalid_o[p]` = 1 in cycle N+1, and read data is valid in N+1.
- **Simultaneous request with response.** A new grant in cycle N+1 to the same or another port is legal. `rdata_o` in N+1 belongs to the cycle-N read, because the SRAM registers the address on N+1's edge.
- **Single requester.** It is granted every cycle it requests, whatever `ptr_q` is. The pointer still advances past it.
- **All requesting.** Ports are granted strictly in rotation, so worst-case wait is NUM_PORTS-1 cycles.
- **Reset mid-operation.**
  - Asserting `rst_ni` clears `rsp_q` immediately (asynchronous), and an in-flight response is dropped.
  - `ptr_q` returns to 0.
  - Requesters must reissue after reset.
- **Reset deassertion.** The first edge after release can grant. Arbitration starts from port 0.

## Test plan
- **Reset.** Hold `rst_ni` = 0 with `req_i` = 2'b11 → `gnt_o` = 0, `sram_req_o` = 0, `rvalid_o` = 0. Release → next cycle `gnt_o` = 2'b01.
- **Single port write then read.**
  - Port 1 writes 0xDEADBEEF, `be` = 0xFFFFFFFF, to addr 0x10.
  - Port 1 then reads 0x10.
  - Expect `rvalid_o` = 2'b10 one cycle after each grant, and `rdata_o` = 0xDEADBEEF on the read response.
- **Contention.**
  - Both ports request continuously for 6 cycles, with reads of addr 0x1 (port 0) and 0x2 (port 1) preloaded as 0xA and 0xB.
  - Expect `gnt_o` sequence 01, 10, 01, 10, 01, 10, and `rdata_o` alternating 0xA, 0xB, each one cycle later.
- **Bit-enable merge.**
  - Port 0 writes 0xFFFFFFFF to addr 0x20, which already holds 0x00000000, with `be` = 0x0000FFFF.
  - Then read addr 0x20 → 0x0000FFFF.
- **Reset mid-response.** Port 0 read is granted in cycle N, and `rst_ni` is pulsed low in N+1 before the edge → `rvalid_o` drops to 0 immediately, and `ptr_q` is 0 after release.
- **NUM_PORTS = 3 wrap.**
  - Ports 0 and 2 request continuously → grants alternate 2'b... i.e. port 0, port 2, port 0.
  - The pointer wraps from 2 to 0 and no grant is issued to idle port 1.
